jtkcpu_shifter: RTL

- Multi-cycle, parametrised-width shift/rotate engine for the Konami CPU core; executes the multi-bit shifts (LSRD/ASRD/ASLD/ROLD/RORD by count, plus the W/8-bit variants) that the single-step ALU path cannot.
- Sits beside the ALU; the sequencer pulses start, waits on busy, samples rslt and flags on done.
- Operates on either an 8-bit or a full DW-bit operand, with CC-compatible flag outputs.

---
 rtl/jtkcpu_shifter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/jtkcpu_shifter.sv
// jtkcpu_shifter: multi-cycle shift/rotate engine on an 8-bit or DW-bit operand with CC-style flags.
// Define JTKCPU_SHIFTER_FAST_EN to run up to 4 steps per cen cycle.
module jtkcpu_shifter #(
    parameter int DW = 16,
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    input  logic          start,
    input  logic [2:0]    mode,
    input  logic          wide,
    input  logic [CW-1:0] cnt,
    input  logic [DW-1:0] opnd,
    input  logic          c_in,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] rslt,
    output logic          c_out,
    output logic          v_out,
    output logic          z_out,
    output logic          n_out
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;
`ifdef JTKCPU_SHIFTER_FAST_EN
    localparam int NS = 4;
`else
    localparam int NS = 1;
`endif

    logic [1:0]    st;
    logic [DW-1:0] r, nr;
    logic          c, v, z, n, nc, nv, w, last;
    logic [2:0]    m;
    logic [CW-1:0] rem, take;
    logic [DW+1:0] t;

    // one step on the active width; returns {v_step, carry, value}, upper bits untouched
    function automatic logic [DW+1:0] step(input logic [DW-1:0] d, input logic ci,
                                           input logic [2:0] op, input logic wd);
        logic [DW-1:0] mask, a, s;
        logic mb, co, left;
        int mi;
        mi   = wd ? DW-1 : 7;
        mask = wd ? '1 : DW'(8'hff);
        a    = d & mask;
        mb   = a[mi];
        left = op == 3'd2 || op == 3'd4;
        co   = left ? mb : a[0];
        s    = left ? a << 1 : a >> 1;
        if (op == 3'd1) s[mi] = mb;
        if (op == 3'd3) s[mi] = ci;
        if (op == 3'd4) s[0] = ci;
        s = (s & mask) | (d & ~mask);
        return op > 3'd4 ? {1'b0, ci, d} : {left & (mb ^ s[mi]), co, s};
    endfunction

    function automatic logic [1:0] zn(input logic [DW-1:0] d, input logic wd);
        return wd ? {d == '0, d[DW-1]} : {d[7:0] == 8'h00, d[7]};
    endfunction

    always_comb begin
        nr = r;
        nc = c;
        nv = v;
        t  = '0;
        for (int k = 0; k < NS; k++) begin
            if (k < int'(rem)) begin
                t  = step(nr, nc, m, w);
                nr = t[DW-1:0];
                nc = t[DW];
                nv = nv | t[DW+1];
            end
        end
        last = int'(rem) <= NS;
        take = last ? rem : CW'(NS);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st  <= IDLE;
            r   <= '0;
            c   <= 1'b0;
            v   <= 1'b0;
            z   <= 1'b0;
            n   <= 1'b0;
            m   <= '0;
            w   <= 1'b0;
            rem <= '0;
        end else if (cen) begin
            if (st == IDLE) begin
                if (start) begin
                    r      <= opnd;
                    c      <= c_in;
                    v      <= 1'b0;
                    m      <= mode;
                    w      <= wide;
                    rem    <= cnt;
                    {z, n} <= zn(opnd, wide);
                    st     <= cnt == '0 ? DONE : SHIFT;
                end
            end else if (st == SHIFT) begin
                r      <= nr;
                c      <= nc;
                v      <= nv;
                rem    <= rem - take;
                {z, n} <= zn(nr, w);
                st     <= last ? DONE : SHIFT;
            end else begin
                st <= IDLE;
            end
        end
    end

    assign busy  = st != IDLE;
    assign done  = st == DONE;
    assign rslt  = r;
    assign c_out = c;
    assign v_out = v;
    assign z_out = z;
    assign n_out = n;
endmodule
